match_scan_unit: RTL and testbench
==================================

Name: match_scan_unit

Overview:
Parametrised, multi-cycle bit-match comparator between two WIDTH-bit vectors x and y.
- Scans LANE bits per cycle, XNOR per bit.
- Accumulates three results: any-bit-equal, all-bits-equal and a count of matching bits.
- Optional early termination, selected per transaction by mode.
- Valid/ready handshake on input and output. Used as the datapath comparison stage between a register-file source and the downstream result consumer.

Parameters:
WIDTH, 16, compared vector width in bits; must be >= 1.
LANE, 4, bits compared per cycle; WIDTH % LANE must equal 0, otherwise elaboration error.
NBEATS, WIDTH/LANE, derived localparam: beats per full scan.
CNT_W, $clog2(WIDTH+1), derived localparam: match_cnt width.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
x  input  WIDTH  operand A.
y  input  WIDTH  operand B.
mode  input  2  00 FULL, 01 ANY_ET, 10 ALL_ET, 11 reserved (treated as FULL).
out_valid  output  1  results valid.
out_ready  input  1  consumer accepts results.
any_eq  output  1  at least one scanned bit position has equal bits.
all_eq  output  1  every scanned bit position has equal bits.
match_cnt  output  CNT_W  number of equal bit positions scanned.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, in_ready=1, out_valid=0, any_eq=0, all_eq=0, match_cnt=0, beat counter=0.
- FSM states: IDLE, SCAN, HOLD. in_ready=1 only in IDLE; out_valid=1 only in HOLD.
- IDLE -> SCAN on in_valid & in_ready at edge E0.
  - Latch x, y and mode; reserved mode 11 is latched as FULL.
  - Set beat=0, any_eq=0, all_eq=1, match_cnt=0.
  - x, y and mode are ignored outside the accept edge.
- SCAN, beat k covers bits [k*LANE +: LANE]:
  - eq = ~(x ^ y) for the lane slice.
  - any_eq |= |eq; all_eq &= &eq; match_cnt += popcount(eq).
  - All three are registered at edge E0+k+1.
- SCAN -> HOLD transitions:
  - FULL: after beat NBEATS-1 (out_valid high after edge E0+NBEATS).
  - ANY_ET: after the first beat with |eq=1, or after the last beat.
  - ALL_ET: after the first beat with &eq=0, or after the last beat.
  - Early-terminated match_cnt counts only scanned beats.
- HOLD: results and out_valid held stable while out_ready=0. On out_valid & out_ready -> IDLE; in_ready rises the following cycle (no same-cycle turnaround).
- LANE==WIDTH: a single beat, 1-cycle latency.
- match_cnt cannot overflow (max WIDTH fits in CNT_W).
- Reset during SCAN or HOLD aborts immediately: the transaction is discarded, no out_valid is produced, and reset values apply.

Optional Feature:
MATCH_SCAN_MASK_EN
- Defined: adds input port mask [WIDTH].
  - mask is latched with x/y at accept.
  - Bits with mask=0 are don't-care: they are excluded from any_eq and match_cnt, and treated as equal for all_eq.
  - With mask all zero: any_eq=0, all_eq=1, match_cnt=0.
  - Early-termination rules apply to masked eq.
- Undefined: no mask port; all bits are compared.

Decomposition:
- Package match_scan_pkg holds:
  - typedef enum logic[1:0] mode_e {MODE_FULL, MODE_ANY_ET, MODE_ALL_ET, MODE_RSVD}.
  - typedef enum state_e {ST_IDLE, ST_SCAN, ST_HOLD}.
- Sub-module lane_match (combinational, parameter LANE):
  - Inputs: x slice, y slice, optional mask slice.
  - Outputs: eq vector, lane_any, lane_all, lane_cnt.
  - Instantiated once; the top muxes the slice by beat index.

Test Plan (WIDTH=16, LANE=4):
1. x=16'hA5A5, y=16'hA5A5, mode FULL -> out_valid 4 cycles after accept; any_eq=1, all_eq=1, match_cnt=16.
2. x=16'hFFFF, y=16'h0000, mode FULL -> after 4 cycles any_eq=0, all_eq=0, match_cnt=0.
3. x=16'h000F, y=16'h0001, mode ANY_ET -> out_valid 1 cycle after accept; any_eq=1, all_eq=0, match_cnt=1.
4. x=16'h1000, y=16'h0000, mode ALL_ET -> mismatch in beat 3, out_valid after 4 cycles; all_eq=0, any_eq=1, match_cnt=15.
5. Test 1 with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. Handshake on cycle 6; in_ready=1 on the next cycle; a new request is accepted.
6. rst_n asserted during beat 2 of test 1 -> out_valid=0, in_ready=1, match_cnt=0 immediately. After release, repeat test 2 -> correct results.

Source files
------------

// File: rtl/match_scan_pkg.sv
// Shared types for the match_scan_unit bit-match comparator.
package match_scan_pkg;

    typedef enum logic [1:0] {
        MODE_FULL   = 2'b00,
        MODE_ANY_ET = 2'b01,
        MODE_ALL_ET = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Reserved encoding behaves exactly like a full scan.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == MODE_RSVD) ? MODE_FULL : mode_e'(m);
    endfunction

endpackage

// File: rtl/match_scan_lane_match.sv
// Combinational per-beat lane comparator: XNOR, reduction and popcount.
// With MATCH_SCAN_MASK_EN, masked-off bits are don't-care.
module lane_match #(
    parameter  int LANE = 4,
    localparam int LC_W = $clog2(LANE + 1)
) (
    input  logic [LANE-1:0] x_s,
    input  logic [LANE-1:0] y_s,
`ifdef MATCH_SCAN_MASK_EN
    input  logic [LANE-1:0] mask_s,
`endif
    output logic [LANE-1:0] eq,
    output logic            lane_any,
    output logic            lane_all,
    output logic [LC_W-1:0] lane_cnt
);
    import match_scan_pkg::*;

    logic [LANE-1:0] raw_eq;
    logic [LANE-1:0] all_eq_v;

    assign raw_eq = ~(x_s ^ y_s);

`ifdef MATCH_SCAN_MASK_EN
    // Masked bits drop out of any/count but count as equal for all.
    assign eq       = raw_eq & mask_s;
    assign all_eq_v = raw_eq | ~mask_s;
`else
    assign eq       = raw_eq;
    assign all_eq_v = raw_eq;
`endif

    assign lane_any = |eq;
    assign lane_all = &all_eq_v;

    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < LANE; i++)
            lane_cnt = lane_cnt + LC_W'(eq[i]);
    end

endmodule

// File: rtl/match_scan_unit.sv
// Multi-cycle bit-match comparator: scans LANE bits per beat, accumulating
// any/all/count with optional early termination. Optional mask: MATCH_SCAN_MASK_EN.
module match_scan_unit
    import match_scan_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int LANE   = 4,
    localparam int NBEATS = WIDTH / LANE,
    localparam int CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef MATCH_SCAN_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             any_eq,
    output logic             all_eq,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int LC_W   = $clog2(LANE + 1);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    generate
        if (WIDTH < 1 || LANE < 1 || (WIDTH % LANE) != 0) begin : g_bad_cfg
            $error("match_scan_unit: WIDTH must be >= 1 and a multiple of LANE");
        end
    endgenerate

    state_e                       state;
    mode_e                        mode_r;
    logic [BEAT_W-1:0]            beat;
    logic [NBEATS-1:0][LANE-1:0]  x_r;
    logic [NBEATS-1:0][LANE-1:0]  y_r;
`ifdef MATCH_SCAN_MASK_EN
    logic [NBEATS-1:0][LANE-1:0]  mask_r;
`endif

    logic [LANE-1:0] lane_eq;
    logic            lane_any;
    logic            lane_all;
    logic [LC_W-1:0] lane_cnt;
    logic            last_beat;
    logic            done;

    lane_match #(.LANE(LANE)) u_lane (
        .x_s      (x_r[beat]),
        .y_s      (y_r[beat]),
`ifdef MATCH_SCAN_MASK_EN
        .mask_s   (mask_r[beat]),
`endif
        .eq       (lane_eq),
        .lane_any (lane_any),
        .lane_all (lane_all),
        .lane_cnt (lane_cnt)
    );

    // Stop after the last beat, or as soon as the selected result is decided.
    always_comb begin
        last_beat = (beat == LAST_BEAT);
        done      = last_beat;
        case (mode_r)
            MODE_ANY_ET: done = last_beat | lane_any;
            MODE_ALL_ET: done = last_beat | ~lane_all;
            default:     done = last_beat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_FULL;
            beat      <= '0;
            x_r       <= '0;
            y_r       <= '0;
`ifdef MATCH_SCAN_MASK_EN
            mask_r    <= '0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            any_eq    <= 1'b0;
            all_eq    <= 1'b0;
            match_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state     <= ST_SCAN;
                        mode_r    <= norm_mode(mode);
                        x_r       <= x;
                        y_r       <= y;
`ifdef MATCH_SCAN_MASK_EN
                        mask_r    <= mask;
`endif
                        beat      <= '0;
                        in_ready  <= 1'b0;
                        any_eq    <= 1'b0;
                        all_eq    <= 1'b1;
                        match_cnt <= '0;
                    end
                end
                ST_SCAN: begin
                    any_eq    <= any_eq | lane_any;
                    all_eq    <= all_eq & lane_all;
                    match_cnt <= match_cnt + CNT_W'(lane_cnt);
                    beat      <= beat + BEAT_W'(1);
                    if (done) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_scan_unit.sv
// Directed scoreboard bench for match_scan_unit (WIDTH=16, LANE=4).
module tb_match_scan_unit;
    import match_scan_pkg::*;

    localparam int WIDTH = 16;
    localparam int LANE  = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef struct {
        string       tag;
        logic        any;
        logic        all;
        logic [31:0] cnt;
        logic [31:0] lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic [1:0]       mode = 2'b00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             any_eq;
    logic             all_eq;
    logic [CNT_W-1:0] match_cnt;
`ifdef MATCH_SCAN_MASK_EN
    logic [WIDTH-1:0] mask = '1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];

    match_scan_unit #(.WIDTH(WIDTH), .LANE(LANE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
`ifdef MATCH_SCAN_MASK_EN
        .mask      (mask),
`endif
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .any_eq    (any_eq),
        .all_eq    (all_eq),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one request; returns after the accept edge (+1 time unit).
    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, input logic ea, input logic el,
                        input int ec, input int elat);
        exp_t e;
        e.tag = tag; e.any = ea; e.all = el; e.cnt = ec; e.lat = elat;
        sb.push_back(e);
        in_valid = 1'b1; x = a; y = b; mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Garbage after accept must be ignored.
        x = ~a; y = a; mode = ~m;
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic compare_out();
        exp_t e;
        int lat;
        wait_out(lat);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(lat), e.lat);
        check({e.tag, "_any_eq"}, 32'(any_eq), 32'(e.any));
        check({e.tag, "_all_eq"}, 32'(all_eq), 32'(e.all));
        check({e.tag, "_match_cnt"}, 32'(match_cnt), e.cnt);
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] m, input logic ea, input logic el,
                       input int ec, input int elat);
        send(tag, a, b, m, ea, el, ec, elat);
        compare_out();
        @(posedge clk); #1;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [CNT_W-1:0] held_cnt;
        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_any_eq", 32'(any_eq), 32'd0);
        check("rst_all_eq", 32'(all_eq), 32'd0);
        check("rst_match_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run("t1_full_eq",     16'hA5A5, 16'hA5A5, 2'b00, 1'b1, 1'b1, 16, 4);
        run("t2_full_ne",     16'hFFFF, 16'h0000, 2'b00, 1'b0, 1'b0, 0, 4);
        run("t3_any_et",      16'h000F, 16'h0001, 2'b01, 1'b1, 1'b0, 1, 1);
        run("t4_all_et_last", 16'h1000, 16'h0000, 2'b10, 1'b1, 1'b0, 15, 4);
        run("all_et_early",   16'h0001, 16'h0000, 2'b10, 1'b1, 1'b0, 3, 1);
        run("any_et_none",    16'hFFFF, 16'h0000, 2'b01, 1'b0, 1'b0, 0, 4);
        run("rsvd_as_full",   16'h000F, 16'h0001, 2'b11, 1'b1, 1'b0, 13, 4);
        run("all_et_no_mis",  16'h5A5A, 16'h5A5A, 2'b10, 1'b1, 1'b1, 16, 4);

        // Back-pressure: hold results for 5 cycles.
        out_ready = 1'b0;
        send("t5_hold", 16'hA5A5, 16'hA5A5, 2'b00, 1'b1, 1'b1, 16, 4);
        compare_out();
        held_cnt = match_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_in_ready", 32'(in_ready), 32'd0);
            check("t5_hold_cnt", 32'(match_cnt), 32'(held_cnt));
            check("t5_hold_all", 32'(all_eq), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t5_release_valid", 32'(out_valid), 32'd0);
        check("t5_release_in_ready", 32'(in_ready), 32'd1);
        run("t5_next_req", 16'h000F, 16'h0001, 2'b01, 1'b1, 1'b0, 1, 1);

        // Reset during beat 2 of test 1.
        send("t6_aborted", 16'hA5A5, 16'hA5A5, 2'b00, 1'b1, 1'b1, 16, 4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_match_cnt", 32'(match_cnt), 32'd0);
        void'(sb.pop_front());
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_no_valid_after_rst", 32'(out_valid), 32'd0);
        run("t6_t2_after_rst", 16'hFFFF, 16'h0000, 2'b00, 1'b0, 1'b0, 0, 4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
